// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline front end.
// Holds the fetch FSM state encoding, the machine word type and the PC step helper.
package cpu_types_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Sequential PC advance; wraps modulo 2^32 by construction.
    function automatic word_t pc_inc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: loads a new word, holds it while decode stalls,
// or drops its valid bit once decode has consumed it or on a flush.
module ifid_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  hold,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_npc,
    output word_t instru,
    output word_t npc,
    output logic  deen
);

    word_t instr_p1;
    word_t npc_p1;
    logic  vld_p1;

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= '0;
            npc_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            instr_p1 <= load_instr;
            npc_p1   <= load_npc;
            vld_p1   <= 1'b1;
        end else if (!hold) begin
            vld_p1 <= 1'b0;
        end
    end

    assign instru = instr_p1;
    assign npc    = npc_p1;
    assign deen   = vld_p1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, icache handshake, one-entry skid buffer and IF/ID.
// Define FETCH_PERF_EN to add the fetch_count / icache_wait_count counters.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  iREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t PCSrc,
    input  logic  halt,
    output word_t instru,
    output word_t nPC,
    output logic  deen,
    output logic  flush,
`ifdef FETCH_PERF_EN
    output word_t fetch_count,
    output word_t icache_wait_count,
`endif
    output logic  fetch_halted
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    word_t        skid_instr, skid_npc;
    logic         flush_next;
    logic         ifid_load, ifid_clear, from_skid;
    logic         skid_load, skid_clear, word_accept;

    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH;
        else     state <= state_next;
    end

    // Halt beats redirect beats the stall/ihit handshake; HALTED only exits on reset.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        flush_next  = 1'b0;
        ifid_load   = 1'b0;
        ifid_clear  = 1'b0;
        from_skid   = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        word_accept = 1'b0;
        if (state != HALTED) begin
            if (halt) begin
                state_next = HALTED;
                ifid_clear = 1'b1;
                skid_clear = 1'b1;
            end else if (redirect) begin
                state_next = FETCH;
                pc_next    = PCSrc & ~32'd3;
                ifid_clear = 1'b1;
                skid_clear = 1'b1;
                flush_next = 1'b1;
            end else if (state == HOLD) begin
                if (!stall) begin
                    ifid_load  = 1'b1;
                    from_skid  = 1'b1;
                    state_next = FETCH;
                end
            end else if (ihit) begin
                pc_next     = pc_inc(pc);
                word_accept = 1'b1;
                if (!deen || !stall) begin
                    ifid_load = 1'b1;
                end else begin
                    skid_load  = 1'b1;
                    state_next = HOLD;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc    <= PC_INIT;
            flush <= 1'b0;
        end else begin
            pc    <= pc_next;
            flush <= flush_next;
        end
    end

    // Skid buffer: parks the word that arrived while decode was stalled
    always_ff @(posedge CLK) begin
        if (RST || skid_clear) begin
            skid_instr <= '0;
            skid_npc   <= '0;
        end else if (skid_load) begin
            skid_instr <= imemload;
            skid_npc   <= pc_inc(pc);
        end
    end

    ifid_latch u_ifid (
        .clk        (CLK),
        .rst        (RST),
        .load       (ifid_load),
        .hold       (stall),
        .clear      (ifid_clear),
        .load_instr (from_skid ? skid_instr : imemload),
        .load_npc   (from_skid ? skid_npc : pc_inc(pc)),
        .instru     (instru),
        .npc        (nPC),
        .deen       (deen)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count       <= '0;
            icache_wait_count <= '0;
        end else begin
            if (word_accept)
                fetch_count <= fetch_count + 32'd1;
            if (state == FETCH && !ihit)
                icache_wait_count <= icache_wait_count + 32'd1;
        end
    end
`endif

    // Request is gated off during reset so the icache never sees a stale address
    assign iREN         = (state == FETCH) && !RST;
    assign imemaddr     = pc;
    assign fetch_halted = (state == HALTED);

endmodule
